// File: rtl/ysyx_22050133_iter_divider_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding, word width
// and the RISC-V divide-by-zero quotient.
package npcdefine;

    localparam int XLEN_DEFAULT = 64;
    localparam int WLEN         = XLEN_DEFAULT / 2;

    localparam logic [XLEN_DEFAULT-1:0] DIV_ZERO_Q = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2,
        SPEC = 2'd3
    } div_state_e;

endpackage

// File: rtl/ysyx_22050133_div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and report the quotient bit.
module ysyx_22050133_div_step #(
    parameter int XLEN = npcdefine::XLEN_DEFAULT
) (
    input  logic [XLEN:0]   rem,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] dsr,
    output logic [XLEN:0]   rem_next,
    output logic            q_bit
);

    localparam int RW = XLEN + 1;

    logic [XLEN+1:0] wide;
    logic [XLEN+1:0] dsr_ext;

    assign wide     = {rem, dvd_msb};
    assign dsr_ext  = {2'b00, dsr};
    assign q_bit    = (wide >= dsr_ext);
    assign rem_next = q_bit ? RW'(wide - dsr_ext) : RW'(wide);

endmodule

// File: rtl/ysyx_22050133_iter_divider.sv
// Iterative restoring divider for RV64M DIV/DIVU/REM/REMU and their word forms.
// Responds on the div_valid/div_ready/out_valid handshake; word results are sign-extended.
module ysyx_22050133_iter_divider
    import npcdefine::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            div_valid,
    input  logic            divw,
    input  logic            div_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            div_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    function automatic logic [XLEN-1:0] sext_w(input logic [WLEN-1:0] x);
        return {{(XLEN-WLEN){x[WLEN-1]}}, x};
    endfunction

    div_state_e       state, state_next;
    logic [CNT_W-1:0] counter;
    logic [XLEN-1:0]  dvd, dsr, q;
    logic [XLEN:0]    rem;
    logic             q_neg, r_neg, word;

    logic             accept, special, div_zero, overflow;
    logic             a_neg, b_neg;
    logic [XLEN-1:0]  a_op, b_op, a_abs, b_abs, a_sx, min_val;
    logic [XLEN:0]    rem_next;
    logic             q_bit;
    logic [XLEN-1:0]  q_mag, r_mag, fin_q, fin_r;

    // Operands at effective width W, extended to XLEN so one datapath serves both modes.
    assign a_op = !divw ? dividend
                : div_signed ? sext_w(dividend[WLEN-1:0])
                : {{(XLEN-WLEN){1'b0}}, dividend[WLEN-1:0]};
    assign b_op = !divw ? divisor
                : div_signed ? sext_w(divisor[WLEN-1:0])
                : {{(XLEN-WLEN){1'b0}}, divisor[WLEN-1:0]};

    assign a_neg = div_signed & a_op[XLEN-1];
    assign b_neg = div_signed & b_op[XLEN-1];
    assign a_abs = a_neg ? -a_op : a_op;
    assign b_abs = b_neg ? -b_op : b_op;

    // Special-case results are sign-extended from W bits even for unsigned word ops.
    assign a_sx     = divw ? sext_w(dividend[WLEN-1:0]) : dividend;
    assign min_val  = divw ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                           : {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero = (b_op == '0);
    assign overflow = div_signed && (a_op == min_val) && (&b_op);
    assign special  = div_zero | overflow;

    assign accept    = (state == IDLE) && div_valid && !flush;
    assign div_ready = (state == IDLE);

    assign q_mag = q_neg ? -q : q;
    assign r_mag = r_neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    assign fin_q = word ? sext_w(q_mag[WLEN-1:0]) : q_mag;
    assign fin_r = word ? sext_w(r_mag[WLEN-1:0]) : r_mag;

    ysyx_22050133_div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[XLEN-1]),
        .dsr      (dsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = special ? SPEC : CALC;
            CALC:    if (counter == '0) state_next = FIN;
            FIN:     state_next = IDLE;
            SPEC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            counter   <= '0;
            dvd       <= '0;
            dsr       <= '0;
            rem       <= '0;
            q         <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            word      <= 1'b0;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            state     <= state_next;
            out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    word  <= divw;
                    q_neg <= a_neg ^ b_neg;
                    r_neg <= a_neg;
                    if (special) begin
                        // Special results ride in q/rem until SPEC publishes them.
                        q   <= div_zero ? DIV_ZERO_Q : a_sx;
                        rem <= div_zero ? {1'b0, a_sx} : '0;
                    end else begin
                        dvd     <= divw ? {a_abs[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : a_abs;
                        dsr     <= b_abs;
                        rem     <= '0;
                        q       <= '0;
                        counter <= divw ? CNT_W'(WLEN - 1) : CNT_W'(XLEN - 1);
                    end
                end
                CALC: if (!flush) begin
                    rem <= rem_next;
                    q   <= {q[XLEN-2:0], q_bit};
                    dvd <= dvd << 1;
                    if (counter != '0) counter <= counter - 1'b1;
                end
                FIN: if (!flush) begin
                    quotient  <= fin_q;
                    remainder <= fin_r;
                    out_valid <= 1'b1;
                end
                SPEC: if (!flush) begin
                    quotient  <= q;
                    remainder <= rem[XLEN-1:0];
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050133_iter_divider.sv
// Directed bench for the iterative divider: results, handshake timing,
// special cases, flush and asynchronous reset mid-operation.
module tb_ysyx_22050133_iter_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        div_valid = 1'b0;
    logic        divw = 1'b0;
    logic        div_signed = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        div_ready, out_valid;
    logic [63:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    ysyx_22050133_iter_divider #(.XLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .div_valid  (div_valid),
        .divw       (divw),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_ready  (div_ready),
        .out_valid  (out_valid),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Accept one op in cycle 0, scramble the operand ports, then watch up to 80 cycles.
    task automatic run_op(input string tag, input logic w, input logic s,
                          input logic [63:0] a, input logic [63:0] b,
                          input int exp_cyc, input logic [63:0] exp_q, input logic [63:0] exp_r);
        int seen;
        int low;
        seen = -1;
        low  = 0;
        @(negedge clk);
        divw = w; div_signed = s; dividend = a; divisor = b; div_valid = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        dividend  = {$urandom, $urandom};
        divisor   = {$urandom, $urandom};
        divw      = ~w;
        for (int c = 1; c <= 80 && seen < 0; c++) begin
            @(negedge clk);
            if (!div_ready) low++;
            if (out_valid) begin
                seen = c;
                check({tag, "_ready"}, 64'(div_ready), 64'd1);
                check({tag, "_q"}, quotient, exp_q);
                check({tag, "_r"}, remainder, exp_r);
            end
        end
        check({tag, "_cycle"}, 64'(seen), 64'(exp_cyc));
        check({tag, "_busy"}, 64'(low), 64'(exp_cyc - 1));
    endtask

    initial begin
        int pulses;
        int low;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(div_ready), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_q", quotient, 64'd0);
        check("rst_r", remainder, 64'd0);
        rst = 1'b1;

        // Normal ops
        run_op("u100_7", 1'b0, 1'b0, 64'd100, 64'd7, 66, 64'd14, 64'd2);
        run_op("s-7_2", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 66,
               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("u3_10", 1'b0, 1'b0, 64'd3, 64'd10, 66, 64'd0, 64'd3);
        run_op("ws-7_2", 1'b1, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 34,
               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("wuFF_1", 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 34,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd0);

        // Special cases
        run_op("ws_ovf", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2,
               64'hFFFF_FFFF_8000_0000, 64'd0);
        run_op("s_ovf", 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2,
               64'h8000_0000_0000_0000, 64'd0);
        run_op("u5_0", 1'b0, 1'b0, 64'd5, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5);
        run_op("wu_div0", 1'b1, 1'b0, 64'h7777_0000_8000_0000, 64'h5555_0000_0000_0000, 2,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
        run_op("u7_3", 1'b0, 1'b0, 64'd7, 64'd3, 66, 64'd2, 64'd1);

        // Flush in cycle 10 of 100/7: outputs keep 7/3 results, no pulse follows
        @(negedge clk);
        divw = 1'b0; div_signed = 1'b0; dividend = 64'd100; divisor = 64'd7; div_valid = 1'b1;
        @(posedge clk);
        #1 div_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("fl_busy10", 64'(div_ready), 64'd0);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("fl_ready11", 64'(div_ready), 64'd1);
        check("fl_valid11", 64'(out_valid), 64'd0);
        check("fl_q", quotient, 64'd2);
        check("fl_r", remainder, 64'd1);
        pulses = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("fl_pulses", 64'(pulses), 64'd0);

        // Flush together with div_valid: nothing accepted
        divw = 1'b0; div_signed = 1'b0; dividend = 64'd9; divisor = 64'd3;
        div_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin div_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        check("flv_ready", 64'(div_ready), 64'd1);
        run_op("u9_3", 1'b0, 1'b0, 64'd9, 64'd3, 66, 64'd3, 64'd0);

        // Asynchronous reset in cycle 20 of an op
        @(negedge clk);
        divw = 1'b0; div_signed = 1'b0; dividend = 64'd1000; divisor = 64'd9; div_valid = 1'b1;
        @(posedge clk);
        #1 div_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rmid_ready", 64'(div_ready), 64'd1);
        check("rmid_valid", 64'(out_valid), 64'd0);
        check("rmid_q", quotient, 64'd0);
        check("rmid_r", remainder, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        low = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (out_valid) pulses++;
            if (!div_ready) low++;
        end
        check("rmid_pulses", 64'(pulses), 64'd0);
        check("rmid_busy", 64'(low), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
